// File: rtl/vsa_pkg.sv
// Shared constants and the store-entry payload for the VSA data-memory stage.
package vsa_pkg;

  localparam int unsigned VSA_DW    = 5;
  localparam int unsigned VSA_AW    = 5;
  localparam int unsigned VSA_DEPTH = 4;

  typedef struct packed {
    logic [VSA_AW-1:0] addr;
    logic [VSA_DW-1:0] data;
  } store_t;

endpackage

// File: rtl/vsa_store_fifo.sv
// Write-through store queue drained over a valid/ready handshake.
// VSA_DMEM_STORE_COALESCE_EN merges a store into the youngest non-head entry with the same address.
module vsa_store_fifo
  import vsa_pkg::*;
#(
  parameter int unsigned DEPTH = VSA_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic [VSA_AW-1:0]        addr,
  input  logic [VSA_DW-1:0]        wdata,
  input  logic                     ext_ready,
  output logic                     ext_valid,
  output logic [VSA_AW-1:0]        ext_addr,
  output logic [VSA_DW-1:0]        ext_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  store_t          ent_q [DEPTH];
  store_t          out_q, out_n, new_ent;
  logic [PW-1:0]   head_q, tail_q, head_n, tail_n, youngest, widx;
  logic [CW-1:0]   count_q, count_n;
  logic            valid_q, ovf_q, ovf_n;
  logic            pop, full, coal, push, drop, we;

  // Next-state: pointer/count update and the head entry that will be presented next cycle.
  always_comb begin
    new_ent.addr = addr;
    new_ent.data = wdata;
    youngest     = tail_q - PW'(1);
    full         = (count_q == CW'(DEPTH));
    pop          = (count_q != '0) && ext_ready;
`ifdef VSA_DMEM_STORE_COALESCE_EN
    coal         = wr && (count_q >= CW'(2)) && (ent_q[youngest].addr == addr);
`else
    coal         = 1'b0;
`endif
    push         = wr && !coal && (!full || pop);
    drop         = wr && !coal && full && !pop;
    we           = push || coal;
    widx         = coal ? youngest : tail_q;
    head_n       = pop  ? head_q + PW'(1) : head_q;
    tail_n       = push ? tail_q + PW'(1) : tail_q;
    ovf_n        = ovf_q || drop;

    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + CW'(1);
      2'b01:   count_n = count_q - CW'(1);
      default: count_n = count_q;
    endcase

    // The slot written this cycle may become the head (empty push, or pop onto a coalesced entry).
    out_n = out_q;
    if (count_n != '0) begin
      if (we && (widx == head_n)) out_n = new_ent;
      else                        out_n = ent_q[head_n];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      valid_q <= (count_n != '0);
      ovf_q   <= ovf_n;
      out_q   <= out_n;
      if (we) ent_q[widx] <= new_ent;
    end
  end

  assign ext_valid = valid_q;
  assign ext_addr  = out_q.addr;
  assign ext_data  = out_q.data;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/vsa_dmem_wt.sv
// VSA data-memory stage: 32-word local array with zero-latency reads plus a write-through store queue.
// Optional store coalescing in the queue is enabled by VSA_DMEM_STORE_COALESCE_EN.
module vsa_dmem_wt
  import vsa_pkg::*;
#(
  parameter int unsigned DEPTH = VSA_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [VSA_AW-1:0]        addr,
  input  logic [VSA_DW-1:0]        wdata,
  input  logic                     wr,
  output logic [VSA_DW-1:0]        rdata,
  output logic                     ext_valid,
  input  logic                     ext_ready,
  output logic [VSA_AW-1:0]        ext_addr,
  output logic [VSA_DW-1:0]        ext_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned DW    = VSA_DW;
  localparam int unsigned AW    = VSA_AW;
  localparam int unsigned WORDS = 2 ** AW;

  logic [DW-1:0] mem_q [WORDS];

  // Array is written on every store, independent of queue occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

  vsa_store_fifo #(
    .DEPTH (DEPTH)
  ) u_store_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .ext_ready (ext_ready),
    .ext_valid (ext_valid),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .count     (count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_vsa_dmem_wt.sv
// Directed bench for vsa_dmem_wt: a vector table of store/drain cycles plus hand-written reset sequences.
module tb_vsa_dmem_wt;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] addr = '0;
  logic [4:0] wdata = '0;
  logic       wr = 1'b0;
  logic [4:0] rdata;
  logic       ext_valid;
  logic       rdy = 1'b0;
  logic [4:0] ext_addr;
  logic [4:0] ext_data;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vsa_dmem_wt dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wdata     (wdata),
    .wr        (wr),
    .rdata     (rdata),
    .ext_valid (ext_valid),
    .ext_ready (rdy),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .count     (count),
    .overflow  (overflow)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [4:0] addr;
    logic [4:0] wdata;
    logic       rdy;
    logic [4:0] e_rdata;
    logic       e_valid;
    logic [4:0] e_addr;
    logic [4:0] e_data;
    logic [2:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [40];
  int   n_vec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input int rst, input int w, input int a, input int d, input int r,
                     input int er, input int ev, input int ea, input int ed, input int ec,
                     input int eo);
    vec_t v;
    v.rst = 1'(rst); v.wr = 1'(w); v.addr = 5'(a); v.wdata = 5'(d); v.rdy = 1'(r);
    v.e_rdata = 5'(er); v.e_valid = 1'(ev); v.e_addr = 5'(ea); v.e_data = 5'(ed);
    v.e_count = 3'(ec); v.e_ovf = 1'(eo);
    vecs[n_vec] = v;
    n_vec++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; wr = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic chk_ext(input string tag, input logic ev, input logic [4:0] ea,
                         input logic [4:0] ed, input logic [2:0] ec, input logic eo);
    chk({tag, ".valid"}, 32'(ext_valid), 32'(ev));
    chk({tag, ".addr"},  32'(ext_addr),  32'(ea));
    chk({tag, ".data"},  32'(ext_data),  32'(ed));
    chk({tag, ".count"}, 32'(count),     32'(ec));
    chk({tag, ".ovf"},   32'(overflow),  32'(eo));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.rst) begin
      do_reset();
    end else begin
      @(negedge clk);
      wr = v.wr; addr = v.addr; wdata = v.wdata; rdy = v.rdy;
      #1 chk({tag, ".rdata"}, 32'(rdata), 32'(v.e_rdata));
      @(posedge clk);
      #1;
      wr = 1'b0; rdy = 1'b0;
    end
    chk_ext(tag, v.e_valid, v.e_addr, v.e_data, v.e_count, v.e_ovf);
  endtask

  task automatic push(input int a, input int d);
    @(negedge clk);
    wr = 1'b1; addr = 5'(a); wdata = 5'(d); rdy = 1'b0;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  initial begin
    // Overflow then in-order drain; reset state carries ext 5/1A from the hand sequence.
    //  rst wr  a     d     rdy rdata  v  ea    ed    c  ovf
    add(0, 1, 1,    'h11, 0,  0,     1, 1,    'h11, 1, 0);
    add(0, 1, 2,    'h12, 0,  0,     1, 1,    'h11, 2, 0);
    add(0, 1, 3,    'h13, 0,  0,     1, 1,    'h11, 3, 0);
    add(0, 1, 4,    'h14, 0,  0,     1, 1,    'h11, 4, 0);
    add(0, 1, 6,    'h16, 0,  0,     1, 1,    'h11, 4, 1);
    add(0, 0, 6,    0,    0,  'h16,  1, 1,    'h11, 4, 1);
    add(0, 0, 1,    0,    1,  'h11,  1, 2,    'h12, 3, 1);
    add(0, 0, 2,    0,    1,  'h12,  1, 3,    'h13, 2, 1);
    add(0, 0, 3,    0,    1,  'h13,  1, 4,    'h14, 1, 1);
    add(0, 0, 4,    0,    1,  'h14,  0, 4,    'h14, 0, 1);
    add(0, 0, 0,    0,    1,  0,     0, 4,    'h14, 0, 1);
    add(1, 0, 0,    0,    0,  0,     0, 0,    0,    0, 0);
    // Full queue: push with simultaneous pop is accepted.
    add(0, 1, 8,    'h01, 0,  0,     1, 8,    'h01, 1, 0);
    add(0, 1, 9,    'h02, 0,  0,     1, 8,    'h01, 2, 0);
    add(0, 1, 10,   'h03, 0,  0,     1, 8,    'h01, 3, 0);
    add(0, 1, 11,   'h04, 0,  0,     1, 8,    'h01, 4, 0);
    add(0, 1, 7,    'h07, 1,  0,     1, 9,    'h02, 4, 0);
    add(0, 0, 9,    0,    1,  'h02,  1, 10,   'h03, 3, 0);
    add(0, 0, 10,   0,    1,  'h03,  1, 11,   'h04, 2, 0);
    add(0, 0, 11,   0,    1,  'h04,  1, 7,    'h07, 1, 0);
    add(0, 0, 7,    0,    1,  'h07,  0, 7,    'h07, 0, 0);
    // Same-address stores to the youngest entry.
    add(0, 1, 3,    'h01, 0,  0,     1, 3,    'h01, 1, 0);
    add(0, 1, 9,    'h02, 0,  'h02,  1, 3,    'h01, 2, 0);
`ifdef VSA_DMEM_STORE_COALESCE_EN
    add(0, 1, 9,    'h05, 0,  'h02,  1, 3,    'h01, 2, 0);
    add(0, 0, 9,    0,    1,  'h05,  1, 9,    'h05, 1, 0);
    add(0, 0, 0,    0,    1,  0,     0, 9,    'h05, 0, 0);
`else
    add(0, 1, 9,    'h05, 0,  'h02,  1, 3,    'h01, 3, 0);
    add(0, 0, 9,    0,    1,  'h05,  1, 9,    'h02, 2, 0);
    add(0, 0, 9,    0,    1,  'h05,  1, 9,    'h05, 1, 0);
    add(0, 0, 9,    0,    1,  'h05,  0, 9,    'h05, 0, 0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_ext("reset", 1'b0, 5'h00, 5'h00, 3'd0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1 chk($sformatf("reset.rdata%0d", a), 32'(rdata), 32'h0);
    end

    // Single store, hold while stalled, then one-cycle accept.
    @(negedge clk);
    wr = 1'b1; addr = 5'd5; wdata = 5'h1A; rdy = 1'b0;
    #1 chk("st5.rdata_old", 32'(rdata), 32'h0);
    @(posedge clk);
    #1 wr = 1'b0;
    chk("st5.rdata_new", 32'(rdata), 32'h1A);
    chk_ext("st5", 1'b1, 5'd5, 5'h1A, 3'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk_ext($sformatf("hold%0d", i), 1'b1, 5'd5, 5'h1A, 3'd1, 1'b0);
    end
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    chk_ext("pop5", 1'b0, 5'd5, 5'h1A, 3'd0, 1'b0);

    for (int i = 0; i < n_vec; i++) run_vec(i, vecs[i]);

    // Asynchronous reset while draining three entries.
    push(12, 1);
    push(13, 2);
    push(14, 3);
    chk("mid.count", 32'(count), 32'd3);
    @(negedge clk);
    rdy = 1'b1; addr = 5'd12;
    #2 reset_n = 1'b0;
    #1;
    chk_ext("mid.rst", 1'b0, 5'h00, 5'h00, 3'd0, 1'b0);
    chk("mid.rdata12", 32'(rdata), 32'h0);
    @(posedge clk);
    #1 chk_ext("mid.hold", 1'b0, 5'h00, 5'h00, 3'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1; rdy = 1'b0;
    addr = 5'd13;
    #1 chk("mid.rdata13", 32'(rdata), 32'h0);
    addr = 5'd14;
    #1 chk("mid.rdata14", 32'(rdata), 32'h0);
    @(posedge clk);
    #1 chk_ext("mid.after", 1'b0, 5'h00, 5'h00, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vsa_dmem_wt.md
Name: vsa_dmem_wt

Overview:
- Data-side memory stage directly downstream of the 5-bit VSA core.
- Consumes the core's data address, store data and write strobe, and returns load data in the same cycle.
- Holds a local 32-word × 5-bit data array, so loads never stall; the core has no stall input.
- Write-through: every store is also queued in a small FIFO and drained to the external data bus over a valid/ready handshake.

Parameters:
- DW, 5: data word width.
- AW, 5: address width; local array depth is 2**AW = 32.
- DEPTH, 4: store FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  master clock, posedge.
- reset_n  input  1  asynchronous active-low reset.
- addr  input  AW  data address from the core's ALU output register.
- wdata  input  DW  store data from the core's B operand.
- wr  input  1  store strobe, one-cycle pulse in the core's MEM state.
- rdata  output  DW  load data to the core, combinational.
- ext_valid  output  1  head store entry is available.
- ext_ready  input  1  external memory accepts the head entry.
- ext_addr  output  AW  head entry address.
- ext_data  output  DW  head entry data.
- count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
- overflow  output  1  sticky flag: a store was dropped from the FIFO.

Behaviour:
- Reset (async assert, synchronous deassert seen at the next posedge):
  - all 32 array words = 0;
  - FIFO head/tail pointers = 0, count = 0;
  - ext_valid = 0, ext_addr = 0, ext_data = 0, overflow = 0.
- Reset mid-drain: pending entries are discarded and no handshake completes.
- Read path:
  - rdata = mem[addr], combinational, zero latency.
  - If wr is high in the same cycle, rdata returns the old value; the new value is visible from the next cycle.
- Array write: on posedge with wr=1, mem[addr] <= wdata. This happens unconditionally, even when the FIFO is full.
- Push: wr=1 enqueues {addr, wdata} at the tail.
- Pop: ext_valid && ext_ready at a posedge retires the head.
- ext_valid = (count != 0).
  - ext_addr/ext_data are registered from the head entry.
  - They hold stable while ext_valid && !ext_ready.
  - With no entry present they keep their last value.
- Pointers wrap modulo DEPTH, and count tracks occupancy:
  - count = DEPTH with head == tail is full; count = 0 is empty.
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
- Full (count == DEPTH):
  - Push with a simultaneous pop is accepted; count stays DEPTH.
  - Push without a pop is dropped, the array is still written, and overflow <= 1.
- overflow clears only on reset.
- Empty: ext_ready is ignored and no pop occurs; a push makes ext_valid = 1 on the next cycle.
- Back-to-back pushes: the core guarantees at most one push per 5 cycles, but the block must accept a push every cycle.

Optional Feature:
- Macro: VSA_DMEM_STORE_COALESCE_EN.
- With the macro defined: if wr=1, count >= 2 and addr equals the youngest entry's address, that entry's data is overwritten in place.
  - count, the pointers and overflow are unchanged.
  - A same-cycle pop is still honoured.
  - The head entry is never coalesced, because it may be mid-handshake.
- Without the macro: every accepted store occupies its own entry.

Decomposition:
- Package vsa_pkg:
  - DW and AW constants;
  - the store-entry typedef (struct: addr, data);
  - DEPTH default.
- Sub-module vsa_store_fifo: pointers, count, full/empty, overflow and the coalesce logic.
- vsa_dmem_wt: instantiates vsa_store_fifo and contains the 32-word array and read mux.

Test Plan:
- Reset, then read all 32 addresses → rdata = 0 everywhere; ext_valid = 0, count = 0, overflow = 0.
- wr addr=5 wdata=0x1A, ext_ready=0 → next cycle:
  - rdata@5 = 0x1A;
  - ext_valid = 1, ext_addr = 5, ext_data = 0x1A, count = 1;
  - all three hold for 10 cycles; ext_ready=1 for one cycle → count = 0, ext_valid = 0.
- ext_ready=0, stores to 1, 2, 3, 4, then 6 → count = 4, overflow = 1, mem[6] = new data, FIFO entries 1–4 intact.
- Release ext_ready → drain order 1, 2, 3, 4.
- Count = 4 with a push to 7 and ext_ready=1 in the same cycle → count = 4, overflow stays 0, entry 7 is drained last.
- Coalesce (macro on), ext_ready=0:
  - stores (3, 0x01), (9, 0x02), (9, 0x05) → count = 2, drain yields (3, 0x01), (9, 0x05);
  - macro off: count = 3, drain yields (3, 0x01), (9, 0x02), (9, 0x05).
- reset_n pulsed low mid-drain with count = 3 → count = 0, ext_valid = 0 immediately, array cleared, overflow = 0.
